// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock supervisor, clocked by the PLL reference clock.
// It pulses the PLL reset and waits for lock. It then checks that lock holds for a stable
// window before releasing the downstream domain resets one at a time. If lock is lost, it
// re-asserts every domain reset and starts over. After too many failed lock attempts it
// latches FAULT.
//
// Ports:
//   refclk        reference clock (sole clock)
//   rst_n         asynchronous active-low reset
//   pll_locked    asynchronous PLL lock indication, synchronised internally
//   soft_restart  1-cycle pulse, restarts the whole sequence from RESET_PLL
//   clr_cnt       1-cycle pulse, clears loss_cnt
//   pll_rst       active-high PLL reset
//   domain_rst    active-high per-domain resets, bit 0 released first
//   ready         all domains released and lock healthy
//   fault         retry budget exhausted
//   loss_cnt      saturating count of lock-loss events in RELEASE/RUN
//   retry_cnt     failed lock attempts since the last RUN entry
//   state_o       encoded FSM state for debug
//
// state     | meaning
// ----------+--------------------------------------------------------------
// RESET_PLL | pll_rst held high for RST_HOLD_CYCLES
// WAIT_LOCK | waiting for synced lock; a timeout counts a retry
// STABLE    | lock must stay high for LOCK_STABLE_CYCLES in a row
// RELEASE   | domain resets released every STAGGER_CYCLES, bit 0 first
// RUN       | all domains out of reset, lock monitored
// FAULT     | retries exhausted; left only via soft_restart or rst_n
module pll_lock_supervisor #(
    parameter int NUM_OUT             = 4,
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int STAGGER_CYCLES      = 8,
    parameter int MAX_RETRY           = 7,
    parameter int CNT_W               = 8
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               soft_restart,
    input  logic               clr_cnt,
    output logic               pll_rst,
    output logic [NUM_OUT-1:0] domain_rst,
    output logic               ready,
    output logic               fault,
    output logic [CNT_W-1:0]   loss_cnt,
    output logic [7:0]         retry_cnt,
    output logic [2:0]         state_o
);

    localparam int MAX_A = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RST_HOLD_CYCLES
                                                                   : LOCK_STABLE_CYCLES;
    localparam int MAX_B = (LOCK_TIMEOUT_CYCLES > NUM_OUT * STAGGER_CYCLES) ? LOCK_TIMEOUT_CYCLES
                                                                            : NUM_OUT * STAGGER_CYCLES;
    localparam int MAX_ALL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_ALL + 1);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [7:0]         retry_n;
    logic               loss_evt;
    logic [NUM_OUT-1:0] dom_n;
    logic               sync1, lock_s;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        retry_n  = retry_cnt;
        loss_evt = 1'b0;
        if (soft_restart) begin
            state_n = S_RESET_PLL;
            cnt_n   = '0;
            retry_n = 8'd0;
        end else begin
            case (state)
                S_RESET_PLL: begin
                    if (cnt == CW'(RST_HOLD_CYCLES - 1)) begin
                        state_n = S_WAIT_LOCK;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_n = S_STABLE;
                        cnt_n   = '0;
                    end else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        retry_n = retry_cnt + 8'd1;
                        cnt_n   = '0;
                        state_n = (retry_n == 8'(MAX_RETRY)) ? S_FAULT : S_RESET_PLL;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    // A dropout here is just an unqualified lock, not a loss event.
                    if (!lock_s) begin
                        state_n = S_WAIT_LOCK;
                        cnt_n   = '0;
                    end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
                        state_n = S_RELEASE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!lock_s) begin
                        loss_evt = 1'b1;
                        state_n  = S_RESET_PLL;
                        cnt_n    = '0;
                    end else if (cnt == CW'((NUM_OUT - 1) * STAGGER_CYCLES)) begin
                        state_n = S_RUN;
                        cnt_n   = '0;
                        retry_n = 8'd0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        loss_evt = 1'b1;
                        state_n  = S_RESET_PLL;
                        cnt_n    = '0;
                    end
                end
                S_FAULT: begin
                    state_n = S_FAULT;
                end
                default: begin
                    state_n = S_RESET_PLL;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Domain resets are a function of the next state and count, so that the registered value
    // lines up with state: bit i drops once the RELEASE count reaches i*STAGGER_CYCLES.
    always_comb begin
        dom_n = '1;
        if (state_n == S_RUN) begin
            dom_n = '0;
        end else if (state_n == S_RELEASE) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (cnt_n >= CW'(i * STAGGER_CYCLES)) begin
                    dom_n[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            lock_s     <= 1'b0;
            state      <= S_RESET_PLL;
            cnt        <= '0;
            retry_cnt  <= 8'd0;
            loss_cnt   <= '0;
            pll_rst    <= 1'b1;
            domain_rst <= '1;
            ready      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            sync1      <= pll_locked;
            lock_s     <= sync1;
            state      <= state_n;
            cnt        <= cnt_n;
            retry_cnt  <= retry_n;
            pll_rst    <= (state_n == S_RESET_PLL) || (state_n == S_FAULT);
            domain_rst <= dom_n;
            ready      <= (state_n == S_RUN);
            fault      <= (state_n == S_FAULT);
            if (clr_cnt) begin
                loss_cnt <= '0;
            end else if (loss_evt && (loss_cnt != '1)) begin
                loss_cnt <= loss_cnt + CNT_W'(1);
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor. Any change in the output bundle is matched against a queue
// of expected snapshots. Each snapshot also carries the number of cycles since the previous
// change, so both values and timing are checked.
module tb_pll_lock_supervisor;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       soft_restart;
    logic       clr_cnt;
    logic       pll_rst;
    logic [3:0] domain_rst;
    logic       ready;
    logic       fault;
    logic [1:0] loss_cnt;
    logic [7:0] retry_cnt;
    logic [2:0] state_o;

    always #5 refclk = ~refclk;

    pll_lock_supervisor #(
        .NUM_OUT            (4),
        .RST_HOLD_CYCLES    (4),
        .LOCK_STABLE_CYCLES (16),
        .LOCK_TIMEOUT_CYCLES(64),
        .STAGGER_CYCLES     (2),
        .MAX_RETRY          (3),
        .CNT_W              (2)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .soft_restart(soft_restart),
        .clr_cnt     (clr_cnt),
        .pll_rst     (pll_rst),
        .domain_rst  (domain_rst),
        .ready       (ready),
        .fault       (fault),
        .loss_cnt    (loss_cnt),
        .retry_cnt   (retry_cnt),
        .state_o     (state_o)
    );

    logic [19:0] snap;
    assign snap = {state_o, pll_rst, domain_rst, ready, fault, loss_cnt, retry_cnt};

    logic [19:0] exp_q[$];
    int          dw_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          last_chg    = 0;
    int          idx         = 0;
    logic [19:0] prev        = 'x;
    logic [19:0] e;
    int          d;

    function automatic logic [19:0] mk(input int st, input logic pr, input logic [3:0] dm,
                                       input logic r, input logic f, input int l, input int rt);
        return {st[2:0], pr, dm, r, f, l[1:0], rt[7:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic push(input logic [19:0] s, input int dw);
        exp_q.push_back(s);
        dw_q.push_back(dw);
    endtask

    // RELEASE sequence through RUN entry: bit 0 on entry, then every 2 cycles, RUN 1 cycle later.
    task automatic push_release(input int l);
        push(mk(3, 0, 4'hE, 0, 0, l, 0), 16);
        push(mk(3, 0, 4'hC, 0, 0, l, 0), 2);
        push(mk(3, 0, 4'h8, 0, 0, l, 0), 2);
        push(mk(3, 0, 4'h0, 0, 0, l, 0), 2);
        push(mk(4, 0, 4'h0, 1, 0, l, 0), 1);
    endtask

    // Called 2 cycles after RUN entry: drop lock for 3 cycles, relock, run back to RUN.
    task automatic loss_cycle(input bit with_clr, input int l);
        push(mk(0, 1, 4'hF, 0, 0, l, 0), 5);
        push(mk(1, 0, 4'hF, 0, 0, l, 0), 4);
        push(mk(2, 0, 4'hF, 0, 0, l, 0), 1);
        push_release(l);
        pll_locked = 1'b0;
        if (with_clr) begin
            repeat (2) @(negedge refclk);
            clr_cnt = 1'b1;
            @(negedge refclk);
            clr_cnt = 1'b0;
        end else begin
            repeat (3) @(negedge refclk);
        end
        pll_locked = 1'b1;
        repeat (30) @(negedge refclk);
    endtask

    always @(negedge refclk) begin
        cyc++;
        if (snap !== prev) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_change: got %h, expected no change", snap);
            end else begin
                e = exp_q.pop_front();
                d = dw_q.pop_front();
                check($sformatf("outputs_%0d", idx), 32'(snap), 32'(e));
                if (d >= 0) check($sformatf("dwell_%0d", idx), 32'(cyc - last_chg), 32'(d));
            end
            prev     = snap;
            last_chg = cyc;
            idx++;
        end
    end

    initial begin
        #100000;
        miscompares++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        rst_n        = 1'b1;
        pll_locked   = 1'b0;
        soft_restart = 1'b0;
        clr_cnt      = 1'b0;
        #1 rst_n     = 1'b0;

        // cold start
        push(mk(0, 1, 4'hF, 0, 0, 0, 0), -1);
        push(mk(1, 0, 4'hF, 0, 0, 0, 0), 6);
        push(mk(2, 0, 4'hF, 0, 0, 0, 0), 9);
        push_release(0);
        repeat (3) @(negedge refclk);
        rst_n = 1'b1;
        repeat (10) @(negedge refclk);
        pll_locked = 1'b1;
        repeat (30) @(negedge refclk);

        // lock drop in RUN, then a one-cycle dropout during STABLE
        push(mk(0, 1, 4'hF, 0, 0, 1, 0), 7);
        push(mk(1, 0, 4'hF, 0, 0, 1, 0), 4);
        push(mk(2, 0, 4'hF, 0, 0, 1, 0), 3);
        push(mk(1, 0, 4'hF, 0, 0, 1, 0), 10);
        push(mk(2, 0, 4'hF, 0, 0, 1, 0), 1);
        push_release(1);
        pll_locked = 1'b0;
        repeat (7) @(negedge refclk);
        pll_locked = 1'b1;
        repeat (10) @(negedge refclk);
        pll_locked = 1'b0;
        @(negedge refclk);
        pll_locked = 1'b1;
        repeat (28) @(negedge refclk);

        // saturation of the 2-bit loss counter, then clear coinciding with a loss event
        loss_cycle(1'b0, 2);
        loss_cycle(1'b0, 3);
        loss_cycle(1'b0, 3);
        loss_cycle(1'b0, 3);
        loss_cycle(1'b1, 0);

        // never locks: three timeouts to FAULT, soft_restart, relock, async reset mid-RELEASE
        push(mk(0, 1, 4'hF, 0, 0, 1, 0), 5);
        push(mk(1, 0, 4'hF, 0, 0, 1, 0), 4);
        push(mk(0, 1, 4'hF, 0, 0, 1, 1), 64);
        push(mk(1, 0, 4'hF, 0, 0, 1, 1), 4);
        push(mk(0, 1, 4'hF, 0, 0, 1, 2), 64);
        push(mk(1, 0, 4'hF, 0, 0, 1, 2), 4);
        push(mk(5, 1, 4'hF, 0, 1, 1, 3), 64);
        push(mk(0, 1, 4'hF, 0, 0, 1, 0), 4);
        push(mk(1, 0, 4'hF, 0, 0, 1, 0), 4);
        push(mk(2, 0, 4'hF, 0, 0, 1, 0), 3);
        push(mk(3, 0, 4'hE, 0, 0, 1, 0), 16);
        push(mk(3, 0, 4'hC, 0, 0, 1, 0), 2);
        push(mk(0, 1, 4'hF, 0, 0, 0, 0), 1);
        pll_locked = 1'b0;
        repeat (210) @(negedge refclk);
        soft_restart = 1'b1;
        @(negedge refclk);
        soft_restart = 1'b0;
        repeat (4) @(negedge refclk);
        pll_locked = 1'b1;
        repeat (21) @(negedge refclk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'(snap), 32'(mk(0, 1, 4'hF, 0, 0, 0, 0)));
        repeat (3) @(negedge refclk);

        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL leftover_expected: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
